// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one uart_tx between two byte-stream requesters.
// An owner holds the serializer for a whole packet; each packet is followed by an idle gap.
module uart_tx_arbiter #(
    parameter int unsigned GAP_CLKS   = 16,
    parameter int unsigned STALL_CLKS = 65535
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [7:0] req0_byte,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_byte,
    input  logic       req1_last,
    output logic       req1_ready,
    output logic       tx_dv,
    output logic [7:0] tx_byte,
    input  logic       tx_done,
    input  logic       tx_active,
    output logic [1:0] grant,
    output logic       busy,
    output logic       abort
);

    localparam logic [15:0] GapLast   = 16'(GAP_CLKS);
    localparam logic [15:0] StallLast = 16'(STALL_CLKS - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StSend, StGap} state_e;

    state_e      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic        rr_q, rr_d;
    logic        tx_dv_q, tx_dv_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic        abort_q, abort_d;
    logic        last_q, last_d;
    logic        first_q, first_d;
    logic [15:0] stall_q, stall_d;
    logic [15:0] gap_q, gap_d;

    logic owner;
    logic xfer;

    assign owner = grant_q[1];

    // The tx_active gate also holds off the first load after a mid-frame reset.
    assign req0_ready = (state_q == StLoad) & grant_q[0] & req0_valid & ~tx_active;
    assign req1_ready = (state_q == StLoad) & grant_q[1] & req1_valid & ~tx_active;
    assign xfer       = req0_ready | req1_ready;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_d      = rr_q;
        tx_dv_d   = 1'b0;
        tx_byte_d = tx_byte_q;
        abort_d   = 1'b0;
        last_d    = last_q;
        first_d   = first_q;
        stall_d   = stall_q;
        gap_d     = gap_q;

        unique case (state_q)
            StIdle: begin
                if (req0_valid | req1_valid) begin
                    if (req0_valid & req1_valid) begin
                        grant_d = rr_q ? 2'b10 : 2'b01;
                    end else begin
                        grant_d = req1_valid ? 2'b10 : 2'b01;
                    end
                    first_d = 1'b1;
                    stall_d = 16'd0;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (xfer) begin
                    tx_byte_d = owner ? req1_byte : req0_byte;
                    last_d    = owner ? req1_last : req0_last;
                    tx_dv_d   = 1'b1;
                    first_d   = 1'b0;
                    stall_d   = 16'd0;
                    state_d   = StSend;
                end else if (!first_q) begin
                    // Fires on the cycle the count would reach STALL_CLKS.
                    if (stall_q == StallLast) begin
                        abort_d = 1'b1;
                        grant_d = 2'b00;
                        rr_d    = ~owner;
                        stall_d = 16'd0;
                        state_d = StGap;
                    end else begin
                        stall_d = stall_q + 16'd1;
                    end
                end
            end
            StSend: begin
                // A done pulse coincident with our own start strobe belongs to an older frame.
                if (tx_done && !tx_dv_q) begin
                    if (last_q) begin
                        grant_d = 2'b00;
                        rr_d    = ~owner;
                        state_d = StGap;
                    end else begin
                        state_d = StLoad;
                    end
                end
            end
            StGap: begin
                if (gap_q == GapLast) begin
                    gap_d   = 16'd0;
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            grant_q   <= 2'b00;
            rr_q      <= 1'b0;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= 8'd0;
            abort_q   <= 1'b0;
            last_q    <= 1'b0;
            first_q   <= 1'b1;
            stall_q   <= 16'd0;
            gap_q     <= 16'd0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_q      <= rr_d;
            tx_dv_q   <= tx_dv_d;
            tx_byte_q <= tx_byte_d;
            abort_q   <= abort_d;
            last_q    <= last_d;
            first_q   <= first_d;
            stall_q   <= stall_d;
            gap_q     <= gap_d;
        end
    end

    assign tx_dv   = tx_dv_q;
    assign tx_byte = tx_byte_q;
    assign grant   = grant_q;
    assign abort   = abort_q;
    assign busy    = (state_q != StIdle);

endmodule
